// File: rtl/ex_stage.sv
// Execute stage: combinational ALU result, HI/LO register file, and a
// radix-2 restoring divider that freezes the front of the pipeline while busy.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  waddr_i,
    input  logic        we_i,
    input  logic [31:0] link_addr_i,
    input  logic [31:0] inst_i,
    input  logic [5:0]  stall,
    output logic [31:0] wdata_o,
    output logic [4:0]  waddr_o,
    output logic        we_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 6;

    localparam logic [7:0] OP_NOP    = 8'b0000_0000;
    localparam logic [7:0] OP_AND    = 8'b0010_0100;
    localparam logic [7:0] OP_OR     = 8'b0010_0101;
    localparam logic [7:0] OP_XOR    = 8'b0010_0110;
    localparam logic [7:0] OP_NOR    = 8'b0010_0111;
    localparam logic [7:0] OP_LUI    = 8'b0101_1100;
    localparam logic [7:0] OP_SLL    = 8'b0111_1100;
    localparam logic [7:0] OP_SRL    = 8'b0000_0010;
    localparam logic [7:0] OP_SRA    = 8'b0000_0011;
    localparam logic [7:0] OP_SLT    = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU   = 8'b0010_1011;
    localparam logic [7:0] OP_ADDU   = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU   = 8'b0010_0011;
    localparam logic [7:0] OP_MFHI   = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI   = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO   = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO   = 8'b0001_0011;
    localparam logic [7:0] OP_MULT   = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU  = 8'b0001_1001;
    localparam logic [7:0] OP_DIV    = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU   = 8'b0001_1011;
    localparam logic [7:0] OP_JAL    = 8'b0101_0000;
    localparam logic [7:0] OP_JALR   = 8'b0000_1001;
    localparam logic [7:0] OP_BLTZAL = 8'b0100_1010;
    localparam logic [7:0] OP_BGEZAL = 8'b0100_1011;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DIV_ON  = 2'd1;
    localparam logic [1:0] S_DIV_END = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] hi_q, lo_q;

    logic            stallreq_c;
    logic            div_wr_c;
    logic [XLEN-1:0] alu_c;
    logic            is_div_c;
    logic            is_sdiv_c;
    logic [XLEN+1:0] trial_c;
    logic            step_ok_c;
    logic [XLEN-1:0] step_rem_c;
    logic [XLEN-1:0] step_quo_c;
    logic [63:0]     prod_s_c;
    logic [63:0]     prod_u_c;
    logic            unused_inputs;

    assign unused_inputs = ^{inst_i, stall[5:4], stall[2:0]};

    assign is_div_c  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_sdiv_c = (aluop_i == OP_DIV);

    assign prod_s_c = 64'($signed(reg1_i)) * 64'($signed(reg2_i));
    assign prod_u_c = 64'(reg1_i) * 64'(reg2_i);

    // One restoring step: shift next dividend bit into the partial remainder and try to subtract.
    assign trial_c    = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
    assign step_ok_c  = ~trial_c[XLEN+1];
    assign step_rem_c = step_ok_c ? trial_c[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign step_quo_c = {quo_q[XLEN-2:0], step_ok_c};

    // Divider next-state and control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        stallreq_c = 1'b0;
        div_wr_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_div_c) begin
                    stallreq_c = 1'b1;
                    rem_d      = '0;
                    cnt_d      = '0;
                    if (reg2_i == '0) begin
                        quo_d   = '0;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                        state_d = S_DIV_END;
                    end else begin
                        quo_d   = (is_sdiv_c && reg1_i[XLEN-1]) ? (~reg1_i + 32'd1) : reg1_i;
                        dvs_d   = (is_sdiv_c && reg2_i[XLEN-1]) ? (~reg2_i + 32'd1) : reg2_i;
                        negq_d  = is_sdiv_c && (reg1_i[XLEN-1] ^ reg2_i[XLEN-1]);
                        negr_d  = is_sdiv_c && reg1_i[XLEN-1];
                        state_d = S_DIV_ON;
                    end
                end
            end
            S_DIV_ON: begin
                stallreq_c = 1'b1;
                cnt_d      = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    quo_d   = negq_q ? (~step_quo_c + 32'd1) : step_quo_c;
                    rem_d   = negr_q ? (~step_rem_c + 32'd1) : step_rem_c;
                    state_d = S_DIV_END;
                end else begin
                    quo_d = step_quo_c;
                    rem_d = step_rem_c;
                end
            end
            S_DIV_END: begin
                if (!stall[3]) begin
                    div_wr_c = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    // HI/LO commit: divider result has priority, other writers only when EX is not held.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (div_wr_c) begin
            hi_q <= rem_q;
            lo_q <= quo_q;
        end else if (!stall[3]) begin
            case (aluop_i)
                OP_MULT:  {hi_q, lo_q} <= prod_s_c;
                OP_MULTU: {hi_q, lo_q} <= prod_u_c;
                OP_MTHI:  hi_q <= reg1_i;
                OP_MTLO:  lo_q <= reg1_i;
                default: ;
            endcase
        end
    end

    // Result mux toward EX/MEM.
    always_comb begin
        alu_c = '0;
        case (aluop_i)
            OP_ADDU:  alu_c = reg1_i + reg2_i;
            OP_SUBU:  alu_c = reg1_i - reg2_i;
            OP_AND:   alu_c = reg1_i & reg2_i;
            OP_OR:    alu_c = reg1_i | reg2_i;
            OP_XOR:   alu_c = reg1_i ^ reg2_i;
            OP_NOR:   alu_c = ~(reg1_i | reg2_i);
            OP_SLT:   alu_c = ($signed(reg1_i) < $signed(reg2_i)) ? 32'd1 : 32'd0;
            OP_SLTU:  alu_c = (reg1_i < reg2_i) ? 32'd1 : 32'd0;
            OP_LUI:   alu_c = reg2_i;
            OP_SLL:   alu_c = reg2_i << reg1_i[4:0];
            OP_SRL:   alu_c = reg2_i >> reg1_i[4:0];
            OP_SRA:   alu_c = 32'($signed(reg2_i) >>> reg1_i[4:0]);
            OP_MFHI:  alu_c = hi_q;
            OP_MFLO:  alu_c = lo_q;
            OP_JAL, OP_JALR, OP_BLTZAL, OP_BGEZAL: alu_c = link_addr_i;
            OP_NOP:   alu_c = '0;
            default:  alu_c = '0;
        endcase
    end

    assign wdata_o    = rst ? '0 : alu_c;
    assign waddr_o    = rst ? '0 : waddr_i;
    assign we_o       = rst ? 1'b0 : we_i;
    assign stallreq_o = rst ? 1'b0 : stallreq_c;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table plus HI/LO, multiply,
// divide, stall-hold and reset-abort sequences.
module tb_ex_stage;

    localparam logic [7:0] OP_NOP   = 8'b0000_0000;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_LUI   = 8'b0101_1100;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_JAL   = 8'b0101_0000;
    localparam logic [7:0] OP_BGEZAL = 8'b0100_1011;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i, reg2_i, link_addr_i, inst_i;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic [5:0]  stall;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic [4:0]  waddr_o;
    logic        we_o, stallreq_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] link;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .waddr_i(waddr_i), .we_i(we_i), .link_addr_i(link_addr_i), .inst_i(inst_i),
        .stall(stall), .wdata_o(wdata_o), .waddr_o(waddr_o), .we_o(we_o),
        .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [5:0] st);
        aluop_i = op;
        reg1_i  = r1;
        reg2_i  = r2;
        stall   = st;
    endtask

    // Issue a divide, count stall-request cycles, then pass the result edge.
    task automatic run_div(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [5:0] st, output int n);
        set_op(op, r1, r2, st);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stallreq_o) n++;
            else break;
        end
        tick;
        aluop_i = OP_NOP;
    endtask

    initial begin
        int n;
        logic saw_stall;

        vecs[0]  = '{OP_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 5'd5,  1'b1, 32'h0000_0000};
        vecs[1]  = '{OP_SUBU, 32'h0000_0005, 32'h0000_0007, 32'h0, 5'd6,  1'b1, 32'hFFFF_FFFE};
        vecs[2]  = '{OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 5'd7,  1'b1, 32'h00F0_00F0};
        vecs[3]  = '{OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h0, 5'd8,  1'b0, 32'h1234_5678};
        vecs[4]  = '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 5'd9,  1'b1, 32'hF0F0_0F0F};
        vecs[5]  = '{OP_NOR,  32'h0F0F_0F0F, 32'hF000_0000, 32'h0, 5'd10, 1'b1, 32'h00F0_F0F0};
        vecs[6]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 5'd11, 1'b1, 32'h0000_0001};
        vecs[7]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 5'd12, 1'b1, 32'h0000_0000};
        vecs[8]  = '{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 5'd13, 1'b1, 32'h0000_0000};
        vecs[9]  = '{OP_LUI,  32'h0000_0000, 32'hABCD_0000, 32'h0, 5'd14, 1'b1, 32'hABCD_0000};
        vecs[10] = '{OP_SLL,  32'h0000_0024, 32'h0000_0001, 32'h0, 5'd15, 1'b1, 32'h0000_0010};
        vecs[11] = '{OP_SRL,  32'h0000_0004, 32'h8000_0000, 32'h0, 5'd16, 1'b1, 32'h0800_0000};
        vecs[12] = '{OP_SRA,  32'h0000_0004, 32'h8000_0000, 32'h0, 5'd17, 1'b1, 32'hF800_0000};
        vecs[13] = '{OP_JAL,  32'h1111_1111, 32'h2222_2222, 32'h0040_0008, 5'd31, 1'b1, 32'h0040_0008};
        vecs[14] = '{OP_BGEZAL, 32'h0, 32'h0, 32'h0040_0100, 5'd31, 1'b1, 32'h0040_0100};
        vecs[15] = '{OP_NOP,  32'hDEAD_BEEF, 32'h1234_5678, 32'h9, 5'd3, 1'b1, 32'h0000_0000};

        // Reset with busy-looking inputs: outputs must be forced low.
        rst = 1'b1;
        set_op(OP_ADDU, 32'h1, 32'h2, 6'd0);
        waddr_i = 5'd3; we_i = 1'b1; link_addr_i = '0; inst_i = 32'h0000_0021;
        tick;
        tick;
        @(negedge clk);
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_we", {31'b0, we_o}, 32'h0);
        check("rst_waddr", {27'b0, waddr_o}, 32'h0);
        set_op(OP_DIV, 32'h7, 32'h2, 6'd0);
        #1;
        check("rst_stallreq", {31'b0, stallreq_o}, 32'h0);
        tick;
        rst = 1'b0;
        set_op(OP_NOP, 32'h0, 32'h0, 6'd0);
        #1;
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);

        // Combinational vector table.
        for (int i = 0; i < 16; i++) begin
            set_op(vecs[i].op, vecs[i].r1, vecs[i].r2, 6'd0);
            link_addr_i = vecs[i].link;
            waddr_i = vecs[i].waddr;
            we_i = vecs[i].we;
            @(negedge clk);
            check($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].exp);
            check($sformatf("vec%0d_waddr", i), {27'b0, waddr_o}, {27'b0, vecs[i].waddr});
            check($sformatf("vec%0d_we", i), {31'b0, we_o}, {31'b0, vecs[i].we});
            check($sformatf("vec%0d_nostall", i), {31'b0, stallreq_o}, 32'h0);
            tick;
        end

        // Multiply and HI/LO moves.
        set_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, 6'd0);
        tick;
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFFE);
        set_op(OP_MULTU, 32'h3, 32'h5, 6'b001000);
        tick;
        check("mult_stalled_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_stalled_lo", lo_o, 32'hFFFF_FFFE);
        set_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 6'd0);
        tick;
        check("multu_hi", hi_o, 32'h0000_0001);
        check("multu_lo", lo_o, 32'hFFFF_FFFE);
        set_op(OP_MTHI, 32'hCAFE_0001, 32'h0, 6'd0);
        tick;
        set_op(OP_MTLO, 32'hBEEF_0002, 32'h0, 6'b001000);
        tick;
        check("mtlo_stalled", lo_o, 32'hFFFF_FFFE);
        set_op(OP_MTLO, 32'hBEEF_0002, 32'h0, 6'd0);
        tick;
        set_op(OP_MFHI, 32'h0, 32'h0, 6'd0);
        #1;
        check("mfhi", wdata_o, 32'hCAFE_0001);
        set_op(OP_MFLO, 32'h0, 32'h0, 6'd0);
        #1;
        check("mflo", wdata_o, 32'hBEEF_0002);

        // Signed divide -7 / 2.
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'h2, 6'd0, n);
        check("div_stall_cycles", 32'(n), 32'd33);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);
        set_op(OP_MFLO, 32'h0, 32'h0, 6'd0);
        #1;
        check("div_mflo", wdata_o, 32'hFFFF_FFFD);
        tick;
        check("div_idle_nostall", {31'b0, stallreq_o}, 32'h0);

        // Divide by zero clears HI/LO after a single stall cycle.
        run_div(OP_DIVU, 32'h1234_5678, 32'h0, 6'd0, n);
        check("div0_stall_cycles", 32'(n), 32'd1);
        check("div0_hi", hi_o, 32'h0);
        check("div0_lo", lo_o, 32'h0);

        // DIV_END held by stall[3]: result waits until release.
        run_div(OP_DIVU, 32'd100, 32'd7, 6'b001000, n);
        check("divu_hold_stall_cycles", 32'(n), 32'd33);
        tick;
        check("divu_hold_hi", hi_o, 32'h0);
        check("divu_hold_lo", lo_o, 32'h0);
        stall = 6'd0;
        tick;
        check("divu_hi", hi_o, 32'd2);
        check("divu_lo", lo_o, 32'd14);

        // Reset mid-divide aborts without writing HI/LO.
        set_op(OP_MTHI, 32'h5555_5555, 32'h0, 6'd0);
        tick;
        set_op(OP_DIV, 32'h7FFF_FFFF, 32'h3, 6'd0);
        repeat (11) tick;
        check("mid_div_stalling", {31'b0, stallreq_o}, 32'h1);
        rst = 1'b1;
        aluop_i = OP_NOP;
        @(negedge clk);
        check("mid_rst_stallreq", {31'b0, stallreq_o}, 32'h0);
        tick;
        rst = 1'b0;
        saw_stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stallreq_o) saw_stall = 1'b1;
        end
        check("abort_no_stall", {31'b0, saw_stall}, 32'h0);
        check("abort_hi", hi_o, 32'h0);
        check("abort_lo", lo_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
